// File: rtl/rgbled_pkg.sv
// Shared WS2812-style timing constants and types for the rgbled driver and decoder.
package rgbled_pkg;

  typedef logic [23:0] rgb_word_t;

  localparam int unsigned WordBits  = 24;
  localparam int unsigned T0HNs     = 400;
  localparam int unsigned T1HNs     = 800;
  localparam int unsigned TRstNs    = 50_000;
  localparam int unsigned ThreshNs  = 600;
  localparam int unsigned MinHighNs = 150;
  localparam int unsigned MaxHighNs = 1500;

  typedef enum logic [1:0] {
    StSync,
    StIdle,
    StHigh,
    StLow
  } dec_state_e;

  // Rounds up so every threshold is at least the nominal duration.
  function automatic int unsigned ns_to_cycles(input int unsigned freq, input int unsigned ns);
    longint unsigned f;
    longint unsigned n;
    longint unsigned cyc;
    f   = 64'(freq);
    n   = 64'(ns);
    cyc = (f * n + 64'd999_999_999) / 64'd1_000_000_000;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/rgbled_dec_fifo.sv
// Two-entry valid/ready word buffer; head entry drives the output directly.
module rgbled_dec_fifo
  import rgbled_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  rgb_word_t wdata_i,
  input  logic      pop_i,
  output rgb_word_t rdata_o,
  output logic      valid_o,
  output logic      full_o
);

  rgb_word_t  head_q;
  rgb_word_t  tail_q;
  logic [1:0] count_q;
  logic       pop;

  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign rdata_o = head_q;
  assign pop     = pop_i & valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (pop) begin
      if (count_q == 2'd2) begin
        head_q <= tail_q;
        if (push_i) begin
          tail_q <= wdata_i;
        end else begin
          count_q <= 2'd1;
        end
      end else if (push_i) begin
        head_q <= wdata_i;
      end else begin
        count_q <= 2'd0;
      end
    end else if (push_i) begin
      case (count_q)
        2'd0: begin
          head_q  <= wdata_i;
          count_q <= 2'd1;
        end
        2'd1: begin
          tail_q  <= wdata_i;
          count_q <= 2'd2;
        end
        default: ;  // full: the word is dropped, top flags overflow
      endcase
    end
  end

endmodule

// File: rtl/rgbled_decoder.sv
// Single-wire NRZ LED stream receiver: decodes pulse widths into 24-bit GRB words.
module rgbled_decoder
  import rgbled_pkg::*;
#(
  parameter int unsigned SysClkFreq = 30_000_000,
  parameter logic        Invert     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        din_i,
  output logic [23:0] word_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_end_o,
  output logic [7:0]  frame_len_o,
  output logic        err_o,
  output logic        overflow_o,
  input  logic        clr_i
);

  localparam int unsigned ThreshCyc  = ns_to_cycles(SysClkFreq, ThreshNs);
  localparam int unsigned MinHighCyc = ns_to_cycles(SysClkFreq, MinHighNs);
  localparam int unsigned MaxHighCyc = ns_to_cycles(SysClkFreq, MaxHighNs);
  localparam int unsigned ResetCyc   = ns_to_cycles(SysClkFreq, TRstNs);
  localparam int unsigned CntW       = $clog2(ResetCyc + 1);

  localparam logic [CntW-1:0] ThreshC  = CntW'(ThreshCyc);
  localparam logic [CntW-1:0] MinHighC = CntW'(MinHighCyc);
  localparam logic [CntW-1:0] MaxHighC = CntW'(MaxHighCyc);
  localparam logic [CntW-1:0] ResetC   = CntW'(ResetCyc);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [4:0]      LastBit  = 5'(WordBits - 1);

  dec_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic [22:0]     shift_q;
  logic [4:0]      bitcnt_q;
  logic [7:0]      words_q;
  logic [7:0]      words_inc;
  logic            push_q;
  rgb_word_t       push_word_q;
  logic            frame_end_q;
  logic [7:0]      frame_len_q;
  logic            err_q;
  logic            overflow_q;

  logic din_meta_q, din_sync_q, din_q;
  logic din_s, rise, fall, bit_val, gap_reached;
  logic fifo_full, fifo_valid;

  // Sync flops idle at the raw line's idle level so reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      din_meta_q <= Invert;
      din_sync_q <= Invert;
      din_q      <= 1'b0;
    end else begin
      din_meta_q <= din_i;
      din_sync_q <= din_meta_q;
      din_q      <= din_s;
    end
  end

  assign din_s       = din_sync_q ^ Invert;
  assign rise        = din_s & ~din_q;
  assign fall        = ~din_s & din_q;
  assign cnt_inc     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntOne;
  assign words_inc   = (words_q == 8'hff) ? words_q : words_q + 8'd1;
  assign bit_val     = (cnt_q >= ThreshC);
  assign gap_reached = (cnt_inc >= ResetC);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StSync;
      cnt_q       <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      words_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      frame_end_q <= 1'b0;
      frame_len_q <= '0;
      err_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_end_q <= 1'b0;
      // Later set assignments override the clear, so a same-cycle set wins.
      if (clr_i) begin
        err_q      <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (push_q && fifo_full && !(fifo_valid && ready_i)) begin
        overflow_q <= 1'b1;
      end

      unique case (state_q)
        StSync: begin
          if (din_s) begin
            cnt_q <= '0;
          end else if (gap_reached) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StIdle: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (cnt_q > MaxHighC || (fall && cnt_q < MinHighC)) begin
            err_q    <= 1'b1;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            words_q  <= '0;
            state_q  <= StSync;
          end else if (fall) begin
            shift_q <= {shift_q[21:0], bit_val};
            cnt_q   <= CntOne;
            state_q <= StLow;
            if (bitcnt_q == LastBit) begin
              push_q      <= 1'b1;
              push_word_q <= {shift_q, bit_val};
              bitcnt_q    <= '0;
              words_q     <= words_inc;
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StLow: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StHigh;
          end else if (gap_reached) begin
            frame_end_q <= 1'b1;
            frame_len_q <= words_q;
            words_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            state_q     <= StIdle;
            if (bitcnt_q != 5'd0) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  rgbled_dec_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_q),
    .wdata_i (push_word_q),
    .pop_i   (ready_i),
    .rdata_o (word_o),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign valid_o     = fifo_valid;
  assign frame_end_o = frame_end_q;
  assign frame_len_o = frame_len_q;
  assign err_o       = err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_rgbled_decoder.sv
// Directed bench for rgbled_decoder at 30 MHz: nominal frames, thresholds, errors, buffering.
module tb_rgbled_decoder;

  localparam int T0H    = 12;
  localparam int T1H    = 24;
  localparam int BitCyc = 38;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [23:0] word;
  logic        valid;
  logic        ready;
  logic        frame_end;
  logic [7:0]  frame_len;
  logic        err;
  logic        overflow;
  logic        clr;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  logic [23:0] popped[$];

  always #5 clk = ~clk;

  rgbled_decoder #(
    .SysClkFreq (30_000_000),
    .Invert     (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_i       (din),
    .word_o      (word),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_end_o (frame_end),
    .frame_len_o (frame_len),
    .err_o       (err),
    .overflow_o  (overflow),
    .clr_i       (clr)
  );

  // Observe handshakes and frame pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) popped.push_back(word);
    if (rst_n && frame_end) fe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pop_at(input int i);
    if (i < popped.size()) return popped[i];
    return 24'hxxxxxx;
  endfunction

  // Entered and left just after a rising edge; din holds v for n edges.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int hi);
    hold(1'b1, hi);
    hold(1'b0, BitCyc - hi);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i] ? T1H : T0H);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    logic [23:0] w;
    logic [19:0] tail;
    logic [11:0] part;
    int          highs[4];

    din   = 1'b0;
    ready = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_eq("rst_word", word, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_frame_end", frame_end, 0);
    check_eq("rst_frame_len", frame_len, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_overflow", overflow, 0);

    // Nominal frame with the last bit's latency measured.
    hold(1'b0, 1500);
    w = 24'hFF0080;
    for (int i = 23; i >= 1; i--) send_bit(w[i] ? T1H : T0H);
    hold(1'b1, T0H);
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("latency_3clk", valid, 0);
    @(posedge clk);
    #1;
    check_eq("latency_4clk", valid, 1);
    hold(1'b0, 1600);
    check_eq("nom_word", word, 24'hFF0080);
    check_eq("nom_valid", valid, 1);
    check_eq("nom_frame_end", fe_cnt, 1);
    check_eq("nom_frame_len", frame_len, 1);
    check_eq("nom_err", err, 0);
    ready = 1'b1;
    hold(1'b0, 4);
    check_eq("nom_pop", pop_at(0), 24'hFF0080);
    check_eq("nom_drained", valid, 0);

    // Thresholds: 18 -> 1, 17 -> 0, 5 -> 0.
    highs = '{18, 17, 5, 18};
    for (int i = 0; i < 4; i++) send_bit(highs[i]);
    tail = 20'h5A5A5;
    for (int i = 19; i >= 0; i--) send_bit(tail[i] ? T1H : T0H);
    hold(1'b0, 1600);
    check_eq("thr_word", pop_at(1), 24'h95A5A5);
    check_eq("thr_err", err, 0);
    check_eq("thr_frame_len", frame_len, 1);

    // Too-short high: error, then bits before the next gap are ignored.
    send_bit(4);
    check_eq("short_err", err, 1);
    send_word(24'h00FFFF);
    hold(1'b0, 1600);
    check_eq("short_no_word", popped.size(), 2);
    check_eq("short_no_frame", fe_cnt, 2);
    send_word(24'h123456);
    hold(1'b0, 1600);
    check_eq("resync_word", pop_at(2), 24'h123456);
    check_eq("resync_frame", fe_cnt, 3);
    pulse_clr();
    check_eq("clr_err", err, 0);

    // Overflow: three words into a stalled two-entry buffer.
    ready = 1'b0;
    send_word(24'h111111);
    send_word(24'h222222);
    send_word(24'h333333);
    hold(1'b0, 1600);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_head", word, 24'h111111);
    check_eq("ovf_frame_len", frame_len, 3);
    ready = 1'b1;
    hold(1'b0, 4);
    check_eq("ovf_pop_a", pop_at(3), 24'h111111);
    check_eq("ovf_pop_b", pop_at(4), 24'h222222);
    check_eq("ovf_pop_cnt", popped.size(), 5);
    check_eq("ovf_sticky", overflow, 1);
    pulse_clr();
    check_eq("clr_overflow", overflow, 0);

    // Partial word at frame end.
    part = 12'hABC;
    for (int i = 11; i >= 0; i--) send_bit(part[i] ? T1H : T0H);
    hold(1'b0, 1600);
    check_eq("part_err", err, 1);
    check_eq("part_frame_end", fe_cnt, 5);
    check_eq("part_frame_len", frame_len, 0);
    check_eq("part_no_word", popped.size(), 5);
    pulse_clr();

    // Over-long high.
    send_bit(T1H);
    hold(1'b1, 46);
    hold(1'b0, 20);
    check_eq("long_err", err, 1);
    hold(1'b0, 1600);
    check_eq("long_no_frame", fe_cnt, 5);

    // Buffered word plus a partial one, then reset mid-word.
    ready = 1'b0;
    send_word(24'hC0FFEE);
    hold(1'b0, 1600);
    check_eq("pre_rst_word", word, 24'hC0FFEE);
    check_eq("pre_rst_len", frame_len, 1);
    for (int i = 0; i < 10; i++) send_bit(T1H);
    hold(1'b1, 10);
    rst_n = 1'b0;
    din   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("mid_rst_word", word, 0);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_frame_end", frame_end, 0);
    check_eq("mid_rst_frame_len", frame_len, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_overflow", overflow, 0);

    // After reset: a frame before the first gap is ignored, the next decodes.
    ready = 1'b1;
    send_word(24'h0F0F0F);
    hold(1'b0, 1600);
    check_eq("post_rst_ignored", popped.size(), 5);
    send_word(24'h5AC3E1);
    hold(1'b0, 1600);
    check_eq("post_rst_word", pop_at(5), 24'h5AC3E1);
    check_eq("post_rst_frames", fe_cnt, 7);
    check_eq("post_rst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
